// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver: assembles sync/cmd/pay_hi/pay_lo/checksum
// frames, validates them and publishes the decoded command with one-cycle valid/error strobes.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] c_SYNC_BYTE      = 8'hA5,
    parameter int         c_TIMEOUT_CYCLES = 21700
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic        i_RX_DATA_VALID,
    input  logic [7:0]  i_DATA_RX,
    output logic        o_FRAME_VALID,
    output logic [7:0]  o_CMD,
    output logic [15:0] o_PAYLOAD,
    output logic        o_FRAME_ERR,
    output logic [7:0]  o_ERR_COUNT,
    output logic        o_BUSY,
    output logic [2:0]  o_STATE_DBG
);

    // Handshake: i_DATA_RX is consumed exactly on cycles where i_RX_DATA_VALID is high;
    // there is no backpressure, so every strobe is accepted.

    typedef enum logic [2:0] {
        s_IDLE   = 3'd0,
        s_CMD    = 3'd1,
        s_PAY_HI = 3'd2,
        s_PAY_LO = 3'd3,
        s_CHECK  = 3'd4
    } state_t;

    localparam logic [15:0] c_TMO_LAST = 16'(c_TIMEOUT_CYCLES - 1);

    state_t      state_q,       state_d;
    logic [7:0]  cmd_sh_q,      cmd_sh_d;
    logic [7:0]  pay_hi_q,      pay_hi_d;
    logic [7:0]  pay_lo_q,      pay_lo_d;
    logic [15:0] tmo_q,         tmo_d;
    logic [7:0]  cmd_q,         cmd_d;
    logic [15:0] payload_q,     payload_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q,   frame_err_d;
    logic [7:0]  err_cnt_q,     err_cnt_d;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q       <= s_IDLE;
            cmd_sh_q      <= 8'h00;
            pay_hi_q      <= 8'h00;
            pay_lo_q      <= 8'h00;
            tmo_q         <= 16'h0000;
            cmd_q         <= 8'h00;
            payload_q     <= 16'h0000;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            cmd_sh_q      <= cmd_sh_d;
            pay_hi_q      <= pay_hi_d;
            pay_lo_q      <= pay_lo_d;
            tmo_q         <= tmo_d;
            cmd_q         <= cmd_d;
            payload_q     <= payload_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_sh_d      = cmd_sh_q;
        pay_hi_d      = pay_hi_q;
        pay_lo_d      = pay_lo_q;
        tmo_d         = tmo_q;
        cmd_d         = cmd_q;
        payload_d     = payload_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_cnt_d     = err_cnt_q;

        if (i_RX_DATA_VALID) begin
            // A strobe always beats a coincident timeout expiry.
            tmo_d = 16'h0000;
            case (state_q)
                s_IDLE: begin
                    if (i_DATA_RX == c_SYNC_BYTE) state_d = s_CMD;
                end
                s_CMD: begin
                    cmd_sh_d = i_DATA_RX;
                    state_d  = s_PAY_HI;
                end
                s_PAY_HI: begin
                    pay_hi_d = i_DATA_RX;
                    state_d  = s_PAY_LO;
                end
                s_PAY_LO: begin
                    pay_lo_d = i_DATA_RX;
                    state_d  = s_CHECK;
                end
                s_CHECK: begin
                    if ((cmd_sh_q ^ pay_hi_q ^ pay_lo_q) == i_DATA_RX) begin
                        cmd_d         = cmd_sh_q;
                        payload_d     = {pay_hi_q, pay_lo_q};
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = s_IDLE;
                end
                default: state_d = s_IDLE;
            endcase
        end else if (state_q == s_IDLE) begin
            tmo_d = 16'h0000;
        end else if (tmo_q == c_TMO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = s_IDLE;
            tmo_d       = 16'h0000;
        end else begin
            tmo_d = tmo_q + 16'h0001;
        end

        if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'h01;
    end

    assign o_FRAME_VALID = frame_valid_q;
    assign o_CMD         = cmd_q;
    assign o_PAYLOAD     = payload_q;
    assign o_FRAME_ERR   = frame_err_q;
    assign o_ERR_COUNT   = err_cnt_q;
    assign o_BUSY        = (state_q != s_IDLE);
    assign o_STATE_DBG   = state_q;

endmodule
